paddle_ai: RTL

PADDLE_AI -- requirements
Module: paddle_ai

---
 rtl/paddle_ai.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/paddle_ai.sv
// Paddle autopilot: drives the same active-low up/down buttons as the keypad.
// Serves on game start, tracks a delayed copy of the ball, otherwise recentres.
//
// state  | meaning
// IDLE   | AI disabled or just woken; buttons released
// SERVE  | holding up for SERVE_HOLD cycles to launch the ball
// TRACK  | ball approaching; follow the delayed ball_y
// CENTER | ball receding; return paddle to CENTER_Y
module paddle_ai #(
   parameter int PADDLE_SIZE_Y = 100,
   parameter int BALL_SIZE     = 5,
   parameter int CENTER_Y      = 250,
   parameter int UPPER_Y       = 420,
   parameter int LOWER_Y       = 55,
   parameter int DEADBAND      = 4,
   parameter int SERVE_HOLD    = 5
) (
   input  logic       clk100Hz,
   input  logic       reset,
   input  logic       enable,
   input  logic       side,
   input  logic [1:0] difficulty,
   input  logic       game_idle,
   input  logic [9:0] ball_y,
   input  logic       ball_dir_pos,
   input  logic [9:0] paddle_y,
   output logic       btn_up_n,
   output logic       btn_down_n,
   output logic [1:0] ai_state
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_SERVE  = 2'b01,
      ST_TRACK  = 2'b10,
      ST_CENTER = 2'b11
   } state_t;

   localparam int CW = $clog2(SERVE_HOLD + 1);
   localparam logic signed [10:0] HALF_BALL = 11'(BALL_SIZE / 2);
   localparam logic signed [10:0] HALF_PAD  = 11'(PADDLE_SIZE_Y / 2);
   localparam logic signed [10:0] DB_POS    = 11'(DEADBAND);
   localparam logic signed [10:0] DB_NEG    = -11'(DEADBAND);
   localparam logic signed [10:0] CTR_S     = 11'(CENTER_Y);

   state_t         state_q, state_d;
   logic [CW-1:0]  serve_cnt_q, serve_cnt_d;
   logic [9:0]     dl_q [1:7];
   logic [9:0]     dl_d [1:7];
   logic [9:0]     target_q, target_d;
   logic           game_idle_q, game_idle_d;
   logic           up_n_q, up_n_d;
   logic           down_n_q, down_n_d;

   logic              approaching;
   logic              idle_rise;
   logic signed [10:0] trk_err, ctr_err, sel_err;
   logic              press_up, press_down;

   always_ff @(posedge clk100Hz) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         serve_cnt_q <= '0;
         for (int k = 1; k <= 7; k++) dl_q[k] <= 10'(CENTER_Y);
         target_q    <= 10'(CENTER_Y);
         game_idle_q <= 1'b0;
         up_n_q      <= 1'b1;
         down_n_q    <= 1'b1;
      end else begin
         state_q     <= state_d;
         serve_cnt_q <= serve_cnt_d;
         for (int k = 1; k <= 7; k++) dl_q[k] <= dl_d[k];
         target_q    <= target_d;
         game_idle_q <= game_idle_d;
         up_n_q      <= up_n_d;
         down_n_q    <= down_n_d;
      end
   end

   // Tap 0 is the live input; taps 1..7 are the registered history.
   always_comb begin
      dl_d[1] = ball_y;
      for (int k = 2; k <= 7; k++) dl_d[k] = dl_q[k-1];
      case (difficulty)
         2'd0:    target_d = dl_q[7];
         2'd1:    target_d = dl_q[4];
         2'd2:    target_d = dl_q[2];
         default: target_d = ball_y;
      endcase
      game_idle_d = game_idle;
   end

   always_comb begin
      state_d     = state_q;
      serve_cnt_d = serve_cnt_q;
      press_up    = 1'b0;
      press_down  = 1'b0;

      approaching = side ? ball_dir_pos : ~ball_dir_pos;
      idle_rise   = game_idle & ~game_idle_q;
      trk_err     = ($signed({1'b0, target_q}) + HALF_BALL)
                  - ($signed({1'b0, paddle_y}) + HALF_PAD);
      ctr_err     = CTR_S - $signed({1'b0, paddle_y});

      if (!enable) begin
         state_d     = ST_IDLE;
         serve_cnt_d = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (game_idle) begin
                  state_d     = ST_SERVE;
                  serve_cnt_d = CW'(1);
               end else begin
                  state_d = approaching ? ST_TRACK : ST_CENTER;
               end
            end
            ST_SERVE: begin
               if (serve_cnt_q == CW'(SERVE_HOLD) || !game_idle) begin
                  state_d     = ST_CENTER;
                  serve_cnt_d = '0;
               end else begin
                  serve_cnt_d = serve_cnt_q + CW'(1);
               end
            end
            ST_TRACK: begin
               if (idle_rise)         state_d = ST_IDLE;
               else if (!approaching) state_d = ST_CENTER;
            end
            default: begin
               if (idle_rise)        state_d = ST_IDLE;
               else if (approaching) state_d = ST_TRACK;
            end
         endcase
      end

      // Buttons follow the rule of the state being entered, so a mode switch
      // and its first press land on the same edge.
      sel_err = (state_d == ST_TRACK) ? trk_err : ctr_err;
      case (state_d)
         ST_SERVE: press_up = 1'b1;
         ST_TRACK, ST_CENTER: begin
            press_down = (sel_err > DB_POS);
            press_up   = (sel_err < DB_NEG);
         end
         default: ;
      endcase

      if (paddle_y >= 10'(UPPER_Y)) press_down = 1'b0;
      if (paddle_y <= 10'(LOWER_Y)) press_up   = 1'b0;

      up_n_d   = ~press_up;
      down_n_d = ~press_down;
   end

   assign btn_up_n   = up_n_q;
   assign btn_down_n = down_n_q;
   assign ai_state   = state_q;

endmodule
